// File: rtl/fifo_stream_reader.sv
// Burst reader: pulls burst_len words from an upstream FIFO through a 4-entry buffer onto a valid/ready stream.
// Define FIFO_RD_TIMEOUT_EN to abort a burst after TIMEOUT consecutive FIFO-empty cycles.
module fifo_stream_reader #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 10,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  xfer_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t            state;
    logic [LEN_W-1:0]  remaining;
    logic [DATA_W-1:0] buf_data [4];
    logic [3:0]        buf_last;
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        occ;
    logic              in_flight;
    logic              in_flight_last;
    logic              aborted;
    logic              push;
    logic              pop;

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic [TO_W-1:0] to_cnt;
    logic            err_r;
    assign err = err_r;
`else
    assign aborted = 1'b0;
    assign err     = 1'b0;
`endif

    // Reserve a buffer slot for every read in flight so the buffer can never overflow.
    assign fifo_rd = (state == RUN) && !fifo_empty && (remaining != '0)
                     && ((occ + {2'b00, in_flight}) < 3'd4);
    assign push    = in_flight;
    assign m_valid = (occ != 3'd0);
    assign pop     = m_valid && m_ready;
    assign m_data  = buf_data[rd_ptr];
    // After an abort no entry carries a last tag, so the final drained word is flagged instead.
    assign m_last  = m_valid && (buf_last[rd_ptr] || (aborted && (occ == 3'd1) && !in_flight));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) buf_data[i] <= '0;
            buf_last       <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            occ            <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
        end else begin
            in_flight      <= fifo_rd;
            in_flight_last <= fifo_rd && (remaining == LEN_W'(1));
            if (push) begin
                buf_data[wr_ptr] <= fifo_data;
                buf_last[wr_ptr] <= in_flight_last;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            xfer_cnt  <= '0;
            remaining <= '0;
`ifdef FIFO_RD_TIMEOUT_EN
            to_cnt    <= '0;
            err_r     <= 1'b0;
            aborted   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (pop) xfer_cnt <= xfer_cnt + LEN_W'(1);
            if (fifo_rd) remaining <= remaining - LEN_W'(1);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        remaining <= burst_len;
                        xfer_cnt  <= '0;
`ifdef FIFO_RD_TIMEOUT_EN
                        to_cnt    <= '0;
                        err_r     <= 1'b0;
                        aborted   <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (remaining == '0) begin
                        state <= FLUSH;
                    end
`ifdef FIFO_RD_TIMEOUT_EN
                    else if (fifo_empty) begin
                        if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                            state   <= FLUSH;
                            aborted <= 1'b1;
                            err_r   <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end else begin
                        to_cnt <= '0;
                    end
`endif
                end
                FLUSH: begin
                    if ((occ == 3'd0) && !in_flight) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized self-checking bench for fifo_stream_reader against an in-order word model of the upstream FIFO.
// Build with FIFO_RD_TIMEOUT_EN defined to exercise the timeout abort (TIMEOUT=4).
module tb_fifo_stream_reader;

    localparam int DW = 32;
    localparam int LW = 10;
`ifdef FIFO_RD_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;
    logic          err;
    logic [LW-1:0] xfer_cnt;
    logic          hold_empty = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    fifo_stream_reader #(.DATA_W(DW), .LEN_W(LW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done), .err(err), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model: words written by the tasks, read data returned the cycle after fifo_rd.
    logic [DW-1:0] src_mem [0:1023];
    int unsigned   wr_total = 0;
    int unsigned   rd_idx = 0;
    assign fifo_empty = hold_empty || (rd_idx >= wr_total);

    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_data <= src_mem[rd_idx];
            rd_idx    <= rd_idx + 1;
        end
    end

    // Monitor: records every downstream transfer and counts protocol violations.
    logic [DW-1:0] got_data [$];
    bit            got_last [$];
    int            got_cyc [$];
    int cyc = 0, start_cyc = 0, rd_cycles = 0, valid_cycles = 0, done_cnt = 0, done_cyc = 0;
    int issued = 0, popped = 0, viol_empty = 0, viol_occ = 0, viol_stable = 0;
    bit stall_prev = 0;
    logic [DW-1:0] stall_data = '0;

    always @(negedge clk) begin
        cyc++;
        if (start && !busy && !rst) start_cyc = cyc;
        if (fifo_rd) begin
            rd_cycles++;
            if (fifo_empty) viol_empty++;
            if (issued - popped >= 4) viol_occ++;
            issued++;
        end
        if (m_valid) valid_cycles++;
        if (stall_prev && !rst && (!m_valid || m_data !== stall_data)) viol_stable++;
        if (m_valid && m_ready) begin
            got_data.push_back(m_data);
            got_last.push_back(m_last);
            got_cyc.push_back(cyc);
            popped++;
        end
        stall_prev = m_valid && !m_ready;
        stall_data = m_data;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rst) begin
            popped = issued;
            stall_prev = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            src_mem[wr_total] = $urandom;
            wr_total++;
        end
    endtask

    // rmode: 0 ready always, 1 toggling 1,0,1,0, 2 random; emode 1 adds short empty bubbles.
    task automatic run_burst(input int len, input int rmode, input int emode, input int restart_at,
                             input int budget, output bit timed_out);
        int d0;
        int hold_run;
        d0 = done_cnt;
        hold_run = 0;
        timed_out = 1;
        for (int k = 0; k < budget; k++) begin
            start = (k == 0) || (k == restart_at);
            burst_len = (k == 0) ? LW'(len) : LW'(9);
            m_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((k % 2) == 0) : 1'($urandom_range(0, 1));
            hold_empty = (emode == 1) && (hold_run < 2) && ($urandom_range(0, 3) == 0);
            hold_run = hold_empty ? hold_run + 1 : 0;
            tick();
            if (done_cnt != d0) begin
                timed_out = 0;
                break;
            end
        end
        start = 0;
        m_ready = 1;
        hold_empty = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) tick();
        rst = 0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %0b expected 0", m_valid); end
        n_checks++; if (fifo_rd !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_rd: got %0b expected 0", fifo_rd); end
        n_checks++; if ({done, err, m_last} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {done, err, m_last}); end
        n_checks++; if (xfer_cnt !== '0) begin n_fail++; $display("FAIL reset_xfer_cnt: got %0d expected 0", xfer_cnt); end
        n_checks++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_m_data: got %0h expected 0", m_data); end
    endtask

    task automatic test_full_burst();
        int g0, src0, d0, e0, o0;
        bit to;
        g0 = got_data.size(); src0 = rd_idx; d0 = done_cnt; e0 = viol_empty; o0 = viol_occ;
        push_words(8);
        run_burst(8, 0, 0, -1, 200, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL full_done_timeout: got no done expected done within 200 cycles"); end
        n_checks++; if (got_data.size() - g0 != 8) begin n_fail++; $display("FAIL full_count: got %0d expected 8", got_data.size() - g0); end
        else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++; if (got_data[g0+i] !== src_mem[src0+i]) begin n_fail++; $display("FAIL full_data[%0d]: got %0h expected %0h", i, got_data[g0+i], src_mem[src0+i]); end
                n_checks++; if (got_last[g0+i] !== (i == 7)) begin n_fail++; $display("FAIL full_last[%0d]: got %0b expected %0b", i, got_last[g0+i], i == 7); end
                n_checks++; if (got_cyc[g0+i] != got_cyc[g0] + i) begin n_fail++; $display("FAIL full_consecutive[%0d]: got cycle %0d expected %0d", i, got_cyc[g0+i], got_cyc[g0] + i); end
            end
            n_checks++; if (got_cyc[g0] - start_cyc != 3) begin n_fail++; $display("FAIL full_first_latency: got %0d expected 3", got_cyc[g0] - start_cyc); end
            n_checks++; if (done_cyc <= got_cyc[g0+7] || done_cyc > got_cyc[g0+7] + 2) begin n_fail++; $display("FAIL full_done_cycle: got %0d expected %0d..%0d", done_cyc, got_cyc[g0+7] + 1, got_cyc[g0+7] + 2); end
        end
        n_checks++; if (xfer_cnt !== LW'(8)) begin n_fail++; $display("FAIL full_xfer_cnt: got %0d expected 8", xfer_cnt); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL full_idle_after_done: got busy=%0b done=%0b expected 0 0", busy, done); end
        n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL full_done_pulses: got %0d expected 1", done_cnt - d0); end
        n_checks++; if (viol_empty != e0 || viol_occ != o0) begin n_fail++; $display("FAIL full_rd_rules: got %0d violations expected 0", viol_empty - e0 + viol_occ - o0); end
    endtask

    task automatic test_stall();
        int g0, src0, s0, o0;
        bit to;
        g0 = got_data.size(); src0 = rd_idx; s0 = viol_stable; o0 = viol_occ;
        push_words(5);
        run_burst(5, 1, 0, -1, 200, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL stall_done_timeout: got no done expected done"); end
        n_checks++; if (got_data.size() - g0 != 5) begin n_fail++; $display("FAIL stall_count: got %0d expected 5", got_data.size() - g0); end
        else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++; if (got_data[g0+i] !== src_mem[src0+i] || got_last[g0+i] !== (i == 4)) begin n_fail++; $display("FAIL stall_word[%0d]: got %0h/%0b expected %0h/%0b", i, got_data[g0+i], got_last[g0+i], src_mem[src0+i], i == 4); end
            end
        end
        n_checks++; if (viol_stable != s0) begin n_fail++; $display("FAIL stall_m_data_stable: got %0d changes expected 0", viol_stable - s0); end
        n_checks++; if (viol_occ != o0) begin n_fail++; $display("FAIL stall_occupancy: got %0d reads at full expected 0", viol_occ - o0); end
        n_checks++; if (xfer_cnt !== LW'(5)) begin n_fail++; $display("FAIL stall_xfer_cnt: got %0d expected 5", xfer_cnt); end
    endtask

    task automatic test_zero_len();
        int r0, v0;
        bit to;
        r0 = rd_cycles; v0 = valid_cycles;
        push_words(2);
        run_burst(0, 0, 0, -1, 50, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL zero_done: got no done expected done pulse"); end
        n_checks++; if (rd_cycles != r0) begin n_fail++; $display("FAIL zero_fifo_rd: got %0d reads expected 0", rd_cycles - r0); end
        n_checks++; if (valid_cycles != v0) begin n_fail++; $display("FAIL zero_m_valid: got %0d valid cycles expected 0", valid_cycles - v0); end
        n_checks++; if (err !== 1'b0 || xfer_cnt !== '0) begin n_fail++; $display("FAIL zero_err_cnt: got err=%0b cnt=%0d expected 0 0", err, xfer_cnt); end
    endtask

    task automatic test_start_ignored();
        int g0, src0, d0;
        bit to;
        g0 = got_data.size(); src0 = rd_idx - 0; d0 = done_cnt;
        src0 = rd_idx;
        push_words(4 - (wr_total - rd_idx));
        run_burst(4, 0, 0, 2, 200, to);
        repeat (10) tick();
        n_checks++; if (to) begin n_fail++; $display("FAIL ignore_done: got no done expected done"); end
        n_checks++; if (got_data.size() - g0 != 4) begin n_fail++; $display("FAIL ignore_count: got %0d expected 4", got_data.size() - g0); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (got_data[g0+i] !== src_mem[src0+i]) begin n_fail++; $display("FAIL ignore_data[%0d]: got %0h expected %0h", i, got_data[g0+i], src_mem[src0+i]); end
            end
        end
        n_checks++; if (xfer_cnt !== LW'(4)) begin n_fail++; $display("FAIL ignore_xfer_cnt: got %0d expected 4", xfer_cnt); end
        n_checks++; if (done_cnt - d0 != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL ignore_single_burst: got done=%0d busy=%0b expected 1 0", done_cnt - d0, busy); end
    endtask

    task automatic test_random();
        for (int b = 0; b < 6; b++) begin
            int len, g0, src0, s0, e0, o0;
            bit to;
            len = $urandom_range(1, 12);
            g0 = got_data.size(); src0 = rd_idx; s0 = viol_stable; e0 = viol_empty; o0 = viol_occ;
            push_words(len);
            run_burst(len, 2, 1, -1, 400, to);
            n_checks++; if (to) begin n_fail++; $display("FAIL rand%0d_done: got no done expected done", b); end
            n_checks++; if (got_data.size() - g0 != len) begin n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d", b, got_data.size() - g0, len); end
            else begin
                for (int i = 0; i < len; i++) begin
                    n_checks++; if (got_data[g0+i] !== src_mem[src0+i] || got_last[g0+i] !== (i == len - 1)) begin n_fail++; $display("FAIL rand%0d_word[%0d]: got %0h/%0b expected %0h/%0b", b, i, got_data[g0+i], got_last[g0+i], src_mem[src0+i], i == len - 1); end
                end
            end
            n_checks++; if (xfer_cnt !== LW'(len) || err !== 1'b0) begin n_fail++; $display("FAIL rand%0d_cnt_err: got %0d/%0b expected %0d/0", b, xfer_cnt, err, len); end
            n_checks++; if (viol_stable != s0 || viol_empty != e0 || viol_occ != o0) begin n_fail++; $display("FAIL rand%0d_protocol: got %0d violations expected 0", b, viol_stable - s0 + viol_empty - e0 + viol_occ - o0); end
        end
    endtask

    task automatic test_reset_mid();
        int g0, src0, v0, d0, n;
        bit seen;
        g0 = got_data.size(); src0 = rd_idx;
        push_words(6);
        seen = 0;
        start = 1; burst_len = LW'(6); m_ready = 1;
        tick();
        start = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (got_data.size() - g0 >= 2) begin seen = 1; break; end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL rstmid_two_words: got %0d words expected 2", got_data.size() - g0); end
        rst = 1;
        tick();
        rst = 0;
        n_checks++; if ({fifo_rd, m_valid, m_last, busy, done, err} !== 6'b0) begin n_fail++; $display("FAIL rstmid_flags: got %b expected 000000", {fifo_rd, m_valid, m_last, busy, done, err}); end
        n_checks++; if (xfer_cnt !== '0 || m_data !== '0) begin n_fail++; $display("FAIL rstmid_cnt_data: got %0d/%0h expected 0/0", xfer_cnt, m_data); end
        v0 = valid_cycles; d0 = done_cnt;
        repeat (10) tick();
        n_checks++; if (valid_cycles != v0 || done_cnt != d0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d valid %0d done expected 0 0", valid_cycles - v0, done_cnt - d0); end
        n = got_data.size() - g0;
        n_checks++; if (n > 3) begin n_fail++; $display("FAIL rstmid_words: got %0d expected at most 3", n); end
        for (int i = 0; i < n && i < 3; i++) begin
            n_checks++; if (got_data[g0+i] !== src_mem[src0+i]) begin n_fail++; $display("FAIL rstmid_data[%0d]: got %0h expected %0h", i, got_data[g0+i], src_mem[src0+i]); end
        end
    endtask

    task automatic test_timeout();
        int g0, src0, d0, exp_n, n;
        bit seen;
        if (wr_total - rd_idx < 3) push_words(3 - (wr_total - rd_idx));
        exp_n = wr_total - rd_idx;
        g0 = got_data.size(); src0 = rd_idx; d0 = done_cnt;
        start = 1; burst_len = LW'(6); m_ready = 0;
        tick();
        start = 0;
`ifdef FIFO_RD_TIMEOUT_EN
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (err) begin seen = 1; break; end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL tmo_err_set: got err=0 expected 1 within 40 cycles"); end
        m_ready = 1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done_cnt != d0) begin seen = 1; break; end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL tmo_done: got no done expected done"); end
        n = got_data.size() - g0;
        n_checks++; if (n != exp_n) begin n_fail++; $display("FAIL tmo_count: got %0d expected %0d", n, exp_n); end
        for (int i = 0; i < n && i < exp_n; i++) begin
            n_checks++; if (got_data[g0+i] !== src_mem[src0+i] || got_last[g0+i] !== (i == exp_n - 1)) begin n_fail++; $display("FAIL tmo_word[%0d]: got %0h/%0b expected %0h/%0b", i, got_data[g0+i], got_last[g0+i], src_mem[src0+i], i == exp_n - 1); end
        end
        n_checks++; if (err !== 1'b1 || xfer_cnt !== LW'(exp_n)) begin n_fail++; $display("FAIL tmo_err_cnt: got %0b/%0d expected 1/%0d", err, xfer_cnt, exp_n); end
`else
        seen = 0;
        repeat (10) tick();
        m_ready = 1;
        repeat (40) tick();
        n = got_data.size() - g0;
        n_checks++; if (n != exp_n) begin n_fail++; $display("FAIL stuck_count: got %0d expected %0d", n, exp_n); end
        for (int i = 0; i < n && i < exp_n; i++) begin
            n_checks++; if (got_data[g0+i] !== src_mem[src0+i] || got_last[g0+i] !== 1'b0) begin n_fail++; $display("FAIL stuck_word[%0d]: got %0h/%0b expected %0h/0", i, got_data[g0+i], got_last[g0+i], src_mem[src0+i]); end
        end
        n_checks++; if (busy !== 1'b1 || done_cnt != d0 || err !== 1'b0) begin n_fail++; $display("FAIL stuck_in_run: got busy=%0b done=%0d err=%0b expected 1 0 0", busy, done_cnt - d0, err); end
        rst = 1;
        repeat (2) tick();
        rst = 0;
        n_checks++; if (busy !== 1'b0 || seen) begin n_fail++; $display("FAIL stuck_reset_exit: got busy=%0b expected 0", busy); end
`endif
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_stall();
        test_zero_len();
        test_start_ignored();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
